// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board controls, the processor and cpu_clk_ctrl.
// The master side drives the requests; the slave side is the controller itself.
interface cpu_clk_ctrl_if;
    logic        run_req;
    logic        halt_req;
    logic        step_btn;
    logic        cpu_hlt;
    logic [1:0]  div_sel;
    logic        cpu_ce;
    logic        dclk;
    logic [1:0]  state;
    logic [15:0] tick_count;

    modport master (
        output run_req, halt_req, step_btn, cpu_hlt, div_sel,
        input  cpu_ce, dclk, state, tick_count
    );

    modport slave (
        input  run_req, halt_req, step_btn, cpu_hlt, div_sel,
        output cpu_ce, dclk, state, tick_count
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Sequenced clock-enable controller: HALT, RUN at a selectable rate, or single STEP,
// producing a one-cycle cpu_ce, an LED-friendly dclk level and a pulse counter.
module cpu_clk_ctrl #(
    parameter int unsigned PERIOD = 32'd10_000_000,
    parameter int unsigned HIGH   = 32'd8_000_000,
    parameter int unsigned CW     = 32'd24
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_clk_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_HALTED  = 2'd0,
        S_RUNNING = 2'd1,
        S_STEP    = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Last count value of a period for a given rate; full speed wraps every cycle.
    function automatic logic [CW-1:0] p_m1_f(input logic [1:0] sel);
        logic [CW-1:0] v;
        case (sel)
            2'd0:    v = CW'(PERIOD - 32'd1);
            2'd1:    v = CW'((PERIOD >> 32'd1) - 32'd1);
            2'd2:    v = CW'((PERIOD >> 32'd2) - 32'd1);
            default: v = CNT_ZERO;
        endcase
        return v;
    endfunction

    function automatic logic [CW-1:0] h_f(input logic [1:0] sel);
        logic [CW-1:0] v;
        case (sel)
            2'd0:    v = CW'(HIGH);
            2'd1:    v = CW'(HIGH >> 32'd1);
            2'd2:    v = CW'(HIGH >> 32'd2);
            default: v = {CW{1'b1}};
        endcase
        return v;
    endfunction

    function automatic logic dclk_f(input state_t st, input logic [1:0] sel,
                                    input logic [CW-1:0] cnt);
        logic v;
        case (st)
            S_RUNNING: v = (sel == 2'd3) ? 1'b1 : (cnt < h_f(sel));
            S_STEP:    v = 1'b1;
            default:   v = 1'b0;
        endcase
        return v;
    endfunction

    logic          r_sync1, r_sync2, r_prev;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_sel;
    logic          r_ce;
    logic          r_dclk;
    logic [15:0]   r_tick;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_sel_nxt;
    logic          w_ce_nxt;
    logic          w_dclk_nxt;
    logic          w_step_rise;
    logic          w_stop;

    assign w_step_rise = r_sync2 & ~r_prev;
    assign w_stop      = bus.halt_req | bus.cpu_hlt;

    // Step button synchronizer and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= bus.step_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Next-state, counter, rate latch and pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_ce_nxt    = 1'b0;
        case (r_state)
            S_HALTED: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_stop) begin
                    w_state_nxt = S_HALTED;
                end else if (bus.run_req) begin
                    w_state_nxt = S_RUNNING;
                    w_sel_nxt   = bus.div_sel;
                end else if (w_step_rise) begin
                    w_state_nxt = S_STEP;
                    w_ce_nxt    = 1'b1;
                end else begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_RUNNING: begin
                // Halt beats the period boundary, so no pulse escapes on the halt edge.
                if (w_stop) begin
                    w_state_nxt = S_HALTED;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == p_m1_f(r_sel)) begin
                    w_cnt_nxt = CNT_ZERO;
                    w_ce_nxt  = 1'b1;
                    w_sel_nxt = bus.div_sel;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_STEP: begin
                w_state_nxt = S_HALTED;
                w_cnt_nxt   = CNT_ZERO;
            end
            default: begin
                w_state_nxt = S_HALTED;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
        w_dclk_nxt = dclk_f(w_state_nxt, w_sel_nxt, w_cnt_nxt);
    end

    // Main state registers; dclk is registered from the decoded next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HALTED;
            r_cnt   <= CNT_ZERO;
            r_sel   <= 2'd0;
            r_ce    <= 1'b0;
            r_dclk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ce    <= w_ce_nxt;
            r_dclk  <= w_dclk_nxt;
        end
    end

    // Issued-pulse counter, free-wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 16'h0000;
        end else begin
            r_tick <= r_tick + {15'd0, r_ce};
        end
    end

    assign bus.cpu_ce     = r_ce;
    assign bus.dclk       = r_dclk;
    assign bus.state      = r_state;
    assign bus.tick_count = r_tick;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: expected cpu_ce pulse cycles are queued as
// stimulus is applied and a negedge monitor pops them as pulses appear.
module tb_cpu_clk_ctrl;

    logic clk;
    logic rst_n;
    cpu_clk_ctrl_if bus();

    cpu_clk_ctrl #(.PERIOD(32'd10), .HIGH(32'd8), .CW(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int exp_q[$];
    int exp_tick = 0;
    bit mon_en   = 1'b0;
    int e_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: each cpu_ce must match the head of the expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cpu_ce === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_ce_unexpected: cycle %0d got pulse, expected none", cyc);
                end else begin
                    e_m = exp_q.pop_front();
                    if (e_m != cyc) begin
                        errors++;
                        $display("FAIL cpu_ce_timing: pulse at cycle %0d, expected cycle %0d", cyc, e_m);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
                checks++;
                errors++;
                e_m = exp_q.pop_front();
                $display("FAIL cpu_ce_missing: no pulse at cycle %0d (expected at %0d)", cyc, e_m);
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_run(input logic [1:0] sel, output int e);
        @(negedge clk);
        bus.div_sel = sel;
        bus.run_req = 1'b1;
        @(negedge clk);
        bus.run_req = 1'b0;
        e = cyc;
    endtask

    task automatic halt_now;
        bus.halt_req = 1'b1;
        @(negedge clk);
        bus.halt_req = 1'b0;
    endtask

    task automatic check_halted(input string tag);
        checks++;
        if (bus.state !== 2'd0 || bus.dclk !== 1'b0) begin
            errors++;
            $display("FAIL %s: state=%0d dclk=%b, expected state=0 dclk=0", tag, bus.state, bus.dclk);
        end
    endtask

    task automatic check_tick(input string tag);
        checks++;
        if (bus.tick_count !== exp_tick[15:0]) begin
            errors++;
            $display("FAIL %s: tick_count=%h, expected %h", tag, bus.tick_count, exp_tick[15:0]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.run_req = 1'b0; bus.halt_req = 1'b0; bus.step_btn = 1'b0;
        bus.cpu_hlt = 1'b0; bus.div_sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0 || bus.dclk !== 1'b0 || bus.tick_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: state=%0d ce=%b dclk=%b tick=%h, expected all 0",
                     bus.state, bus.cpu_ce, bus.dclk, bus.tick_count);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check_halted("idle_after_reset");
    endtask

    task automatic test_run_base;
        int e;
        logic exp_d;
        start_run(2'd0, e);
        exp_q.push_back(e + 10); exp_q.push_back(e + 20); exp_q.push_back(e + 30);
        exp_tick += 3;
        while (cyc <= e + 30) begin
            exp_d = ((cyc - e) % 10) < 8;
            checks++;
            if (bus.state !== 2'd1 || bus.dclk !== exp_d) begin
                errors++;
                $display("FAIL run_base_dclk: cycle %0d state=%0d dclk=%b, expected state=1 dclk=%b",
                         cyc - e, bus.state, bus.dclk, exp_d);
            end
            @(negedge clk);
        end
        check_tick("run_base_tick");
        halt_now();
        check_halted("run_base_halt");
    endtask

    task automatic test_rate_change;
        int e;
        logic exp_d;
        start_run(2'd0, e);
        exp_q.push_back(e + 10); exp_q.push_back(e + 15);
        exp_q.push_back(e + 20); exp_q.push_back(e + 25);
        exp_tick += 4;
        while (cyc < e + 27) begin
            if (cyc == e + 3) bus.div_sel = 2'd1;
            if (cyc < e + 10) exp_d = (cyc - e) < 8;
            else              exp_d = ((cyc - e - 10) % 5) < 4;
            checks++;
            if (bus.dclk !== exp_d) begin
                errors++;
                $display("FAIL rate_change_dclk: cycle %0d dclk=%b, expected %b", cyc - e, bus.dclk, exp_d);
            end
            @(negedge clk);
        end
        halt_now();
        bus.div_sel = 2'd0;
        check_halted("rate_change_halt");
        check_tick("rate_change_tick");
    endtask

    task automatic press_step(input int hold);
        int c;
        logic [1:0] exp_s;
        @(negedge clk);
        c = cyc;
        bus.step_btn = 1'b1;
        exp_q.push_back(c + 3);
        exp_tick += 1;
        repeat (hold) begin
            @(negedge clk);
            exp_s = (cyc == c + 3) ? 2'd2 : 2'd0;
            checks++;
            if (bus.state !== exp_s || bus.dclk !== exp_s[1]) begin
                errors++;
                $display("FAIL step_state: cycle %0d state=%0d dclk=%b, expected state=%0d dclk=%b",
                         cyc - c, bus.state, bus.dclk, exp_s, exp_s[1]);
            end
        end
        bus.step_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_step;
        press_step(20);
        check_tick("step_tick_first");
        press_step(4);
        check_tick("step_tick_second");
    endtask

    task automatic test_hlt_boundary;
        int e;
        start_run(2'd0, e);
        wait_until(e + 9);
        bus.cpu_hlt = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd0 || bus.dclk !== 1'b0 || bus.cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL hlt_boundary: state=%0d dclk=%b ce=%b, expected 0 0 0",
                     bus.state, bus.dclk, bus.cpu_ce);
        end
        bus.run_req = 1'b1;
        bus.step_btn = 1'b1;
        @(negedge clk);
        bus.run_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_halted("hlt_ignores_requests");
        end
        bus.step_btn = 1'b0;
        repeat (4) @(negedge clk);
        bus.cpu_hlt = 1'b0;
        repeat (4) @(negedge clk);
        check_halted("hlt_released_idle");
        check_tick("hlt_tick");
    endtask

    task automatic test_full_speed;
        int e, t0, m_last;
        t0 = exp_tick;
        m_last = 65536 - t0 + 2;
        start_run(2'd3, e);
        for (int m = 1; m <= m_last; m++) exp_q.push_back(e + m);
        checks++;
        if (bus.state !== 2'd1 || bus.dclk !== 1'b1) begin
            errors++;
            $display("FAIL full_speed_entry: state=%0d dclk=%b, expected 1 1", bus.state, bus.dclk);
        end
        wait_until(e + 65536 - t0);
        checks++;
        if (bus.tick_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL tick_before_wrap: tick_count=%h, expected ffff", bus.tick_count);
        end
        @(negedge clk);
        checks++;
        if (bus.tick_count !== 16'h0000) begin
            errors++;
            $display("FAIL tick_wrap: tick_count=%h, expected 0000", bus.tick_count);
        end
        @(negedge clk);
        halt_now();
        exp_tick = (t0 + m_last) & 32'hFFFF;
        check_halted("full_speed_halt");
        check_tick("full_speed_tick");
        bus.div_sel = 2'd0;
        bus.run_req = 1'b1;
        bus.halt_req = 1'b1;
        @(negedge clk);
        bus.run_req = 1'b0;
        bus.halt_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_halted("run_and_halt_together");
        end
    endtask

    task automatic test_reset_mid;
        int e;
        start_run(2'd0, e);
        wait_until(e + 5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.cpu_ce !== 1'b0 || bus.dclk !== 1'b0 || bus.tick_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_async: state=%0d ce=%b dclk=%b tick=%h, expected all 0",
                     bus.state, bus.cpu_ce, bus.dclk, bus.tick_count);
        end
        exp_tick = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            check_halted("reset_mid_stays_halted");
        end
        check_tick("reset_mid_tick");
    endtask

    initial begin
        test_reset();
        test_run_base();
        test_rate_change();
        test_step();
        test_hlt_boundary();
        test_full_speed();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
